// File: rtl/board_ctrl_if.sv
// Move/pass request and board status bundle for the 9x9 Go board controller.
// The controller connects through the slave modport, the move source through master.
interface board_ctrl_if;
    logic                   move_ready;
    logic [7:0]             move_in;
    logic                   pass_in;
    logic [8:0][8:0][1:0]   board;
    logic [1:0]             turn;
    logic                   my_turn;
    logic                   move_ack;
    logic                   move_err;
    logic                   game_over;
    logic [7:0]             cap_black;
    logic [7:0]             cap_white;

    modport slave (
        input  move_ready, move_in, pass_in,
        output board, turn, my_turn, move_ack, move_err, game_over, cap_black, cap_white
    );

    modport master (
        output move_ready, move_in, pass_in,
        input  board, turn, my_turn, move_ack, move_err, game_over, cap_black, cap_white
    );
endinterface

// File: rtl/board_ctrl.sv
// 9x9 Go board controller: validates and places stones, removes captured single
// stones one direction per cycle, tracks turn, passes, game end and capture counts.
module board_ctrl #(
    parameter logic [1:0] LOCAL_COLOR = 2'b01
) (
    input  logic         clk_in,
    input  logic         reset,
    board_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        VALIDATE = 3'd1,
        PLACE    = 3'd2,
        CAP      = 3'd3,
        DONE     = 3'd4
    } state_t;

    function automatic logic [1:0] f_other(input logic [1:0] color);
        return (color == 2'b01) ? 2'b10 : 2'b01;
    endfunction

    // True when every in-bounds orthogonal neighbour of (r,c) holds color.
    function automatic logic f_surrounded(
        input logic [8:0][8:0][1:0] b,
        input logic [3:0]           r,
        input logic [3:0]           c,
        input logic [1:0]           color
    );
        logic ok;
        ok = 1'b1;
        ok = ok & ((r == 4'd0) || (b[r - 4'd1][c] == color));
        ok = ok & ((r == 4'd8) || (b[r + 4'd1][c] == color));
        ok = ok & ((c == 4'd0) || (b[r][c - 4'd1] == color));
        ok = ok & ((c == 4'd8) || (b[r][c + 4'd1] == color));
        return ok;
    endfunction

    state_t               r_state;
    logic [3:0]           r_row;
    logic [3:0]           r_col;
    logic [1:0]           r_dir;
    logic                 r_is_pass;
    logic [8:0][8:0][1:0] r_board;
    logic [1:0]           r_turn;
    logic [1:0]           r_pass_cnt;
    logic                 r_game_over;
    logic                 r_move_ack;
    logic                 r_move_err;
    logic                 r_my_turn;
    logic [7:0]           r_cap_black;
    logic [7:0]           r_cap_white;

    logic                 w_valid;
    logic [3:0]           w_nr;
    logic [3:0]           w_nc;
    logic                 w_nb_in;
    logic                 w_capture;
    logic [1:0]           w_turn_next;
    logic [1:0]           w_pass_next;
    logic                 w_go_next;

    // Move legality, current-direction neighbour and capture decision, turn-end values.
    always_comb begin
        w_valid     = (r_row <= 4'd8) && (r_col <= 4'd8) && (r_board[r_row][r_col] == 2'b00);
        w_nr        = r_row;
        w_nc        = r_col;
        w_nb_in     = 1'b0;
        case (r_dir)
            2'd0: begin w_nb_in = (r_row != 4'd0); w_nr = r_row - 4'd1; end
            2'd1: begin w_nb_in = (r_row != 4'd8); w_nr = r_row + 4'd1; end
            2'd2: begin w_nb_in = (r_col != 4'd0); w_nc = r_col - 4'd1; end
            2'd3: begin w_nb_in = (r_col != 4'd8); w_nc = r_col + 4'd1; end
            default: begin w_nb_in = 1'b0; end
        endcase
        if (w_nb_in) begin
            w_capture = (r_board[w_nr][w_nc] == f_other(r_turn)) &&
                        f_surrounded(r_board, w_nr, w_nc, r_turn);
        end else begin
            w_capture = 1'b0;
        end
        w_turn_next = f_other(r_turn);
        if (r_is_pass) begin
            w_pass_next = r_pass_cnt + 2'd1;
        end else begin
            w_pass_next = 2'd0;
        end
        w_go_next   = (w_pass_next == 2'd2);
    end

    // Controller FSM and all registered state/outputs.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state     <= IDLE;
            r_row       <= 4'd0;
            r_col       <= 4'd0;
            r_dir       <= 2'd0;
            r_is_pass   <= 1'b0;
            r_board     <= '0;
            r_turn      <= 2'b01;
            r_pass_cnt  <= 2'd0;
            r_game_over <= 1'b0;
            r_move_ack  <= 1'b0;
            r_move_err  <= 1'b0;
            r_my_turn   <= (LOCAL_COLOR == 2'b01);
            r_cap_black <= 8'd0;
            r_cap_white <= 8'd0;
        end else begin
            r_move_ack <= 1'b0;
            r_move_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!r_game_over && bus.move_ready) begin
                        r_row     <= bus.move_in[7:4];
                        r_col     <= bus.move_in[3:0];
                        r_is_pass <= 1'b0;
                        r_state   <= VALIDATE;
                    end else if (!r_game_over && bus.pass_in) begin
                        r_is_pass <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_state   <= IDLE;
                    end
                end
                VALIDATE: begin
                    if (w_valid) begin
                        r_state    <= PLACE;
                    end else begin
                        r_move_err <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                PLACE: begin
                    r_board[r_row][r_col] <= r_turn;
                    r_dir   <= 2'd0;
                    r_state <= CAP;
                end
                CAP: begin
                    if (w_capture) begin
                        r_board[w_nr][w_nc] <= 2'b00;
                        if (r_turn == 2'b01) begin
                            r_cap_black <= (r_cap_black == 8'hFF) ? 8'hFF : r_cap_black + 8'd1;
                        end else begin
                            r_cap_white <= (r_cap_white == 8'hFF) ? 8'hFF : r_cap_white + 8'd1;
                        end
                    end
                    if (r_dir == 2'd3) begin
                        r_state <= DONE;
                    end else begin
                        r_dir   <= r_dir + 2'd1;
                    end
                end
                DONE: begin
                    // Shared by moves (clears pass run) and passes (extends it).
                    r_move_ack  <= 1'b1;
                    r_turn      <= w_turn_next;
                    r_pass_cnt  <= w_pass_next;
                    r_game_over <= w_go_next;
                    r_my_turn   <= (w_turn_next == LOCAL_COLOR) & ~w_go_next;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.board     = r_board;
    assign bus.turn      = r_turn;
    assign bus.my_turn   = r_my_turn;
    assign bus.move_ack  = r_move_ack;
    assign bus.move_err  = r_move_err;
    assign bus.game_over = r_game_over;
    assign bus.cap_black = r_cap_black;
    assign bus.cap_white = r_cap_white;

endmodule

// File: tb/tb_board_ctrl.sv
// Directed bench for board_ctrl: expected ack/err pulses with their cycle go into a
// scoreboard queue at stimulus time and are popped when the DUT pulses.
module tb_board_ctrl;

    typedef struct {
        string      tag;
        logic [1:0] kind;
        int         cyc;
    } exp_t;

    localparam logic [1:0] K_ACK = 2'b10;
    localparam logic [1:0] K_ERR = 2'b01;

    logic                 clk_in = 1'b0;
    logic                 reset;
    int                   cyc = 0;
    int                   n_checks = 0;
    int                   n_fail = 0;
    exp_t                 sb_q[$];
    logic [8:0][8:0][1:0] m_board;
    logic [7:0]           mv_list [0:14] = '{8'h54, 8'h44, 8'h55, 8'h45, 8'h43, 8'h88, 8'h46,
                                             8'h80, 8'h35, 8'h08, 8'h34, 8'h22, 8'h70, 8'h26, 8'h81};

    board_ctrl_if bus();

    board_ctrl #(.LOCAL_COLOR(2'b01)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [161:0] obs, input logic [161:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pops one expected pulse per observed ack/err and checks its kind and cycle.
    always @(negedge clk_in) begin
        exp_t e;
        if (bus.move_ack || bus.move_err) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", {bus.move_ack, bus.move_err}, 2'b00);
            end else begin
                e = sb_q.pop_front();
                check(e.tag, {bus.move_ack, bus.move_err}, e.kind);
                check({e.tag, "_lat"}, cyc, e.cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic sb_push(input string tag, input logic [1:0] kind, input int lat);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.cyc  = cyc + lat;
        sb_q.push_back(e);
    endtask

    task automatic pulse(input logic mr, input logic ps, input logic [7:0] mv);
        bus.move_ready = mr;
        bus.pass_in    = ps;
        bus.move_in    = mv;
        tick(1);
        bus.move_ready = 1'b0;
        bus.pass_in    = 1'b0;
    endtask

    // kind 2'b00 means no pulse is expected at all.
    task automatic do_op(input string tag, input logic mr, input logic ps, input logic [7:0] mv,
                         input logic [1:0] kind, input int lat);
        if (kind != 2'b00) sb_push(tag, kind, lat);
        pulse(mr, ps, mv);
        tick(10);
        check({tag, "_drain"}, sb_q.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        m_board = '0;
    endtask

    task automatic check_state(input string tag, input logic [1:0] turn, input logic [7:0] capb,
                               input logic [7:0] capw, input logic go, input logic mt);
        check({tag, "_board"}, bus.board, m_board);
        check({tag, "_turn"}, bus.turn, turn);
        check({tag, "_capb"}, bus.cap_black, capb);
        check({tag, "_capw"}, bus.cap_white, capw);
        check({tag, "_go"}, bus.game_over, go);
        check({tag, "_myturn"}, bus.my_turn, mt);
    endtask

    initial begin
        bus.move_ready = 1'b0;
        bus.pass_in    = 1'b0;
        bus.move_in    = 8'h00;
        m_board        = '0;
        reset          = 1'b1;
        tick(3);
        reset = 1'b0;
        m_board = '0;
        check_state("reset", 2'b01, 8'd0, 8'd0, 1'b0, 1'b1);
        check("reset_ack", bus.move_ack, 1'b0);
        check("reset_err", bus.move_err, 1'b0);

        // First black move: ack 7 cycles after the latching edge.
        do_op("mv44", 1'b1, 1'b0, 8'h44, K_ACK, 8);
        m_board[4][4] = 2'b01;
        check_state("mv44", 2'b10, 8'd0, 8'd0, 1'b0, 1'b0);

        // Rejections leave board and turn untouched.
        do_op("occ44", 1'b1, 1'b0, 8'h44, K_ERR, 2);
        do_op("col9", 1'b1, 1'b0, 8'h49, K_ERR, 2);
        do_op("row9", 1'b1, 1'b0, 8'h90, K_ERR, 2);
        check_state("rej", 2'b10, 8'd0, 8'd0, 1'b0, 1'b0);

        // White captures the black corner stone.
        do_op("w10", 1'b1, 1'b0, 8'h10, K_ACK, 8);
        do_op("b00", 1'b1, 1'b0, 8'h00, K_ACK, 8);
        do_op("w01", 1'b1, 1'b0, 8'h01, K_ACK, 8);
        m_board[1][0] = 2'b10;
        m_board[0][1] = 2'b10;
        check_state("capw", 2'b01, 8'd0, 8'd1, 1'b0, 1'b1);

        // A surrounded two-stone white group survives; later a lone corner stone is taken.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            m_board[mv_list[i][7:4]][mv_list[i][3:0]] = (i % 2 == 0) ? 2'b01 : 2'b10;
            do_op($sformatf("seq%0d", i), 1'b1, 1'b0, mv_list[i], K_ACK, 8);
            if (i == 10) check_state("group", 2'b10, 8'd0, 8'd0, 1'b0, 1'b0);
        end
        m_board[8][0] = 2'b00;
        check_state("capb", 2'b10, 8'd1, 8'd0, 1'b0, 1'b0);

        // Pass sequence: a move in between resets the run of passes.
        do_reset();
        do_op("pass1", 1'b0, 1'b1, 8'h00, K_ACK, 2);
        check_state("pass1", 2'b10, 8'd0, 8'd0, 1'b0, 1'b0);
        do_op("w44", 1'b1, 1'b0, 8'h44, K_ACK, 8);
        m_board[4][4] = 2'b10;
        do_op("pass2", 1'b0, 1'b1, 8'h00, K_ACK, 2);
        check_state("pass2", 2'b10, 8'd0, 8'd0, 1'b0, 1'b0);
        do_op("pass3", 1'b0, 1'b1, 8'h00, K_ACK, 2);
        check_state("over", 2'b01, 8'd0, 8'd0, 1'b1, 1'b0);
        do_op("go_mv", 1'b1, 1'b0, 8'h00, 2'b00, 0);
        do_op("go_pass", 1'b0, 1'b1, 8'h00, 2'b00, 0);
        check_state("go_ign", 2'b01, 8'd0, 8'd0, 1'b1, 1'b0);

        // Simultaneous move and pass: move wins, pass dropped.
        do_reset();
        do_op("both", 1'b1, 1'b1, 8'h22, K_ACK, 8);
        m_board[2][2] = 2'b01;
        check_state("both", 2'b10, 8'd0, 8'd0, 1'b0, 1'b0);

        // A request arriving during CAP is dropped.
        sb_push("capign", K_ACK, 8);
        pulse(1'b1, 1'b0, 8'h33);
        tick(3);
        pulse(1'b1, 1'b0, 8'h55);
        tick(10);
        check("capign_drain", sb_q.size(), 0);
        m_board[3][3] = 2'b10;
        check_state("capign", 2'b01, 8'd0, 8'd0, 1'b0, 1'b1);

        // Reset sampled at edge 4 aborts the move without ack.
        pulse(1'b1, 1'b0, 8'h66);
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        m_board = '0;
        tick(10);
        check_state("abort", 2'b01, 8'd0, 8'd0, 1'b0, 1'b1);
        do_op("post", 1'b1, 1'b0, 8'h66, K_ACK, 8);
        m_board[6][6] = 2'b01;
        check_state("post", 2'b10, 8'd0, 8'd0, 1'b0, 1'b0);

        check("sb_final", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/board_ctrl.md
BOARD_CTRL -- requirements
Module: board_ctrl

Interface
REQ-001 The block SHALL have parameter LOCAL_COLOR, default 2'b01, giving the local player's stone colour: 01 black, 10 white.
REQ-002 The block SHALL have port clk_in, input, 1 bit: system clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the clk_in rising edge.
REQ-004 The block SHALL have port move_ready, input, 1 bit: one-cycle pulse requesting placement at move_in.
REQ-005 The block SHALL have port move_in, input, 8 bits: [7:4] row, [3:0] column; legal values are 0..8.
REQ-006 The block SHALL have port pass_in, input, 1 bit: one-cycle pulse meaning the mover passes.
REQ-007 The block SHALL have port board, output, 2 bits x 9 x 9, indexed board[row][col]: 00 empty, 01 black, 10 white; 11 never produced.
REQ-008 The block SHALL have port turn, output, 2 bits: colour to move, 01 or 10.
REQ-009 The block SHALL have port my_turn, output, 1 bit: (turn == LOCAL_COLOR) & ~game_over.
REQ-010 The block SHALL have port move_ack, output, 1 bit: one-cycle pulse when a move or pass commits.
REQ-011 The block SHALL have port move_err, output, 1 bit: one-cycle pulse when a move is rejected.
REQ-012 The block SHALL have port game_over, output, 1 bit: sticky flag set after two consecutive passes.
REQ-013 The block SHALL have ports cap_black and cap_white, outputs, 8 bits each: stones captured by black and by white respectively.

Function
REQ-014 The FSM SHALL have states IDLE, VALIDATE, PLACE, CAP (with a 2-bit direction index 0..3 = up, down, left, right), and DONE.
REQ-015 In IDLE with game_over=0, move_ready=1 SHALL latch move_in and enter VALIDATE; this clock edge is edge 0.
REQ-016 If move_ready and pass_in are high in the same IDLE cycle, move_ready SHALL win and pass_in SHALL be ignored.
REQ-017 In any state other than IDLE, move_ready and pass_in SHALL be ignored (not queued).
REQ-018 VALIDATE SHALL reject a move whose row > 8, column > 8, or target square is not 00.
- On reject: move_err SHALL be 1 for exactly the cycle after edge 1, the FSM SHALL return to IDLE, and board, turn and pass count SHALL be unchanged.
REQ-019 For a valid move, PLACE SHALL write turn into board[row][col] at edge 2.
REQ-020 CAP SHALL take one cycle per direction (edges 3-6). For each direction, the neighbour SHALL be cleared to 00 if all of the following hold:
- the neighbour is in bounds and holds the opponent colour;
- every in-bounds orthogonal neighbour of that stone holds the mover's colour (single-stone capture only; groups of two or more are never removed).
REQ-021 Each capture SHALL increment the mover's counter (cap_black when turn=01, otherwise cap_white), saturating at 255.
REQ-022 At edge 7 the block SHALL do all of the following, then return to IDLE:
- pulse move_ack for one cycle;
- toggle turn (01<->10);
- clear the consecutive-pass count.
Total latency from edge 0 to move_ack is 7 cycles; suicide placement is permitted and is not removed.
REQ-023 In IDLE with game_over=0, pass_in=1 SHALL, at edge 1, pulse move_ack, toggle turn and increment the pass count.
- The board SHALL be unchanged.
- When the count reaches 2, game_over SHALL be set.
REQ-024 While game_over=1, all move_ready and pass_in pulses SHALL be ignored (no ack, no err) until reset.
REQ-025 move_ack and move_err SHALL never be high in the same cycle.

Reset
REQ-026 While reset=1 at a clock edge, the block SHALL clear the board to all 00 and set turn=01, cap_black=0, cap_white=0, pass count=0, game_over=0, move_ack=0, move_err=0 and state=IDLE.
REQ-027 A reset asserted mid-operation (VALIDATE/PLACE/CAP/DONE) SHALL abort the move with no move_ack or move_err, taking effect at that edge.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Reset, then move_ready with move_in=8'h44 -> 7 cycles later move_ack=1, board[4][4]=01, turn=10; with LOCAL_COLOR=01, my_turn goes 1->0.
- Placement on occupied 8'h44, then on 8'h49 -> each gives move_err=1 one cycle after VALIDATE, with no board or turn change.
- Black stone at (0,0) with white at (1,0); white places at (0,1) -> board[0][0]=00, cap_white=1, turn=01.
- Two white stones at (4,4),(4,5) surrounded except (3,4), which black fills -> no capture and cap_black unchanged.
- pass_in, then a move, then pass_in, pass_in -> game_over=1 only after the last pass; a subsequent move_ready gives no ack and no err.
- move_ready and pass_in together; a further move_ready during CAP; reset asserted at edge 4 -> move only, pass ignored; mid-operation pulse dropped; reset clears board with no ack.
